// File: rtl/clk_rst_sequencer.sv
// rtl/clk_rst_sequencer.sv - MMCM reset pulse, lock wait/retry and staggered domain reset release
module clk_rst_sequencer #(
  parameter int N_DOMAINS      = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter int CNT_W          = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 locked_in,
  output logic                 mmcm_rst_o,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 all_ready,
  output logic [7:0]           retry_cnt,
  output logic [7:0]           lock_lost_cnt,
  output logic [2:0]           state_o
);

  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] PLL_TC     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_TC    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_TC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_TC = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DOMAINS - 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t               state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic                 sync_meta, locked_s;
  logic                 mmcm_n, ready_n;
  logic [N_DOMAINS-1:0] rst_out_n;
  logic [7:0]           retry_n, lost_n;
  logic                 lose;

  assign state_o = state_q;

  // Two-flop synchronizer: locked_in comes from the MMCM with no relation to clk
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      sync_meta <= locked_in;
      locked_s  <= sync_meta;
    end
  end

  // Next-state and next-output logic; lock loss after release overrides everything
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    mmcm_n    = mmcm_rst_o;
    rst_out_n = rst_out;
    ready_n   = all_ready;
    retry_n   = retry_cnt;
    lost_n    = lock_lost_cnt;
    lose      = 1'b0;

    case (state_q)
      PLL_RST: begin
        mmcm_n    = 1'b1;
        rst_out_n = '1;
        ready_n   = 1'b0;
        if (cnt_q == PLL_TC) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
          mmcm_n  = 1'b0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt_q == LOCK_TC) begin
          state_n = PLL_RST;
          cnt_n   = '0;
          mmcm_n  = 1'b1;
          if (retry_cnt != 8'hFF) retry_n = retry_cnt + 8'd1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      STABLE: begin
        // a drop here is treated as a glitch: back to waiting, nothing counted
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt_q == STABLE_TC) begin
          state_n = RELEASE;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          lose = 1'b1;
        end else if (cnt_q == STAGGER_TC) begin
          rst_out_n[idx_q] = 1'b0;
          cnt_n            = '0;
          idx_n            = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_n = RUN;
            ready_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) lose = 1'b1;
      end
      default: begin
        state_n   = PLL_RST;
        cnt_n     = '0;
        idx_n     = '0;
        mmcm_n    = 1'b1;
        rst_out_n = '1;
        ready_n   = 1'b0;
      end
    endcase

    if (lose) begin
      state_n   = PLL_RST;
      cnt_n     = '0;
      idx_n     = '0;
      mmcm_n    = 1'b1;
      rst_out_n = '1;
      ready_n   = 1'b0;
      if (lock_lost_cnt != 8'hFF) lost_n = lock_lost_cnt + 8'd1;
    end
  end

  // State, counters and all outputs are registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PLL_RST;
      cnt_q         <= '0;
      idx_q         <= '0;
      mmcm_rst_o    <= 1'b1;
      rst_out       <= '1;
      all_ready     <= 1'b0;
      retry_cnt     <= 8'd0;
      lock_lost_cnt <= 8'd0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      idx_q         <= idx_n;
      mmcm_rst_o    <= mmcm_n;
      rst_out       <= rst_out_n;
      all_ready     <= ready_n;
      retry_cnt     <= retry_n;
      lock_lost_cnt <= lost_n;
    end
  end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb/tb_clk_rst_sequencer.sv - self-checking bench for clk_rst_sequencer
module tb_clk_rst_sequencer;

  localparam int ND   = 3;
  localparam int PRC  = 4;
  localparam int LTO  = 32;
  localparam int STC  = 8;
  localparam int STAG = 4;

  logic          clk;
  logic          rst;
  logic          locked_in;
  logic          mmcm_rst_o;
  logic [ND-1:0] rst_out;
  logic          all_ready;
  logic [7:0]    retry_cnt;
  logic [7:0]    lock_lost_cnt;
  logic [2:0]    state_o;

  int n_cmp = 0;
  int n_bad = 0;

  clk_rst_sequencer #(
    .N_DOMAINS(ND), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO),
    .STABLE_CYCLES(STC), .STAGGER_CYCLES(STAG), .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst), .locked_in(locked_in), .mmcm_rst_o(mmcm_rst_o),
    .rst_out(rst_out), .all_ready(all_ready), .retry_cnt(retry_cnt),
    .lock_lost_cnt(lock_lost_cnt), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: phase plus time spent in it; outputs derived arithmetically
  int m_ph, m_t, m_ret, m_lost;
  bit m_s1, m_s2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic l);
    bit ls;
    if (r) begin
      m_ph = 0; m_t = 0; m_ret = 0; m_lost = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      ls = m_s2; m_s2 = m_s1; m_s1 = l;
      case (m_ph)
        0: if (m_t + 1 == PRC) begin m_ph = 1; m_t = 0; end else m_t++;
        1: if (ls) begin m_ph = 2; m_t = 0; end
           else if (m_t + 1 == LTO) begin m_ph = 0; m_t = 0; if (m_ret < 255) m_ret++; end
           else m_t++;
        2: if (!ls) begin m_ph = 1; m_t = 0; end
           else if (m_t + 1 == STC) begin m_ph = 3; m_t = 0; end
           else m_t++;
        3: if (!ls) begin m_ph = 0; m_t = 0; if (m_lost < 255) m_lost++; end
           else if (m_t + 1 == ND * STAG) begin m_ph = 4; m_t = 0; end
           else m_t++;
        default: if (!ls) begin m_ph = 0; m_t = 0; if (m_lost < 255) m_lost++; end
      endcase
    end
  endtask

  function automatic logic [ND-1:0] model_ro();
    logic [ND-1:0] v;
    v = '1;
    if (m_ph == 4) v = '0;
    else if (m_ph == 3)
      for (int k = 0; k < ND; k++) v[k] = (m_t < (k + 1) * STAG);
    return v;
  endfunction

  task automatic tick(input logic r, input logic l);
    rst = r;
    locked_in = l;
    @(posedge clk);
    model_step(r, l);
    #1;
    check("m_state", 32'(state_o), 32'(m_ph));
    check("m_mmcm", 32'(mmcm_rst_o), 32'(m_ph == 0));
    check("m_rst_out", 32'(rst_out), 32'(model_ro()));
    check("m_ready", 32'(all_ready), 32'(m_ph == 4));
    check("m_retry", 32'(retry_cnt), 32'(m_ret));
    check("m_lost", 32'(lock_lost_cnt), 32'(m_lost));
  endtask

  task automatic wait_ready(input int limit);
    for (int i = 0; i < limit && !all_ready; i++) tick(1'b0, 1'b1);
    check("wait_ready", 32'(all_ready), 32'd1);
  endtask

  typedef struct {
    logic       r;
    logic       l;
    int         n;
    logic [2:0] st;
    logic       mm;
    logic [2:0] ro;
    logic       rdy;
    logic [7:0] ret;
    logic [7:0] lost;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic l, input int n, input logic [2:0] st,
                              input logic mm, input logic [2:0] ro, input logic rdy,
                              input logic [7:0] ret, input logic [7:0] lost);
    vec_t v;
    v.r = r; v.l = l; v.n = n; v.st = st; v.mm = mm; v.ro = ro;
    v.rdy = rdy; v.ret = ret; v.lost = lost;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    locked_in = 1'b0;

    // normal bring-up, loss in RUN, one lock timeout
    vecs.push_back(mk(1, 0,  2, 3'd0, 1, 3'b111, 0, 0, 0));
    vecs.push_back(mk(0, 1,  3, 3'd0, 1, 3'b111, 0, 0, 0));
    vecs.push_back(mk(0, 1,  1, 3'd1, 0, 3'b111, 0, 0, 0));
    vecs.push_back(mk(0, 1,  1, 3'd2, 0, 3'b111, 0, 0, 0));
    vecs.push_back(mk(0, 1,  7, 3'd2, 0, 3'b111, 0, 0, 0));
    vecs.push_back(mk(0, 1,  1, 3'd3, 0, 3'b111, 0, 0, 0));
    vecs.push_back(mk(0, 1,  3, 3'd3, 0, 3'b111, 0, 0, 0));
    vecs.push_back(mk(0, 1,  1, 3'd3, 0, 3'b110, 0, 0, 0));
    vecs.push_back(mk(0, 1,  4, 3'd3, 0, 3'b100, 0, 0, 0));
    vecs.push_back(mk(0, 1,  3, 3'd3, 0, 3'b100, 0, 0, 0));
    vecs.push_back(mk(0, 1,  1, 3'd4, 0, 3'b000, 1, 0, 0));
    vecs.push_back(mk(0, 1,  5, 3'd4, 0, 3'b000, 1, 0, 0));
    vecs.push_back(mk(0, 0,  2, 3'd4, 0, 3'b000, 1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 3'd0, 1, 3'b111, 0, 0, 1));
    vecs.push_back(mk(0, 0,  3, 3'd0, 1, 3'b111, 0, 0, 1));
    vecs.push_back(mk(0, 0,  1, 3'd1, 0, 3'b111, 0, 0, 1));
    vecs.push_back(mk(0, 0, 31, 3'd1, 0, 3'b111, 0, 0, 1));
    vecs.push_back(mk(0, 0,  1, 3'd0, 1, 3'b111, 0, 1, 1));

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) tick(vecs[i].r, vecs[i].l);
      check($sformatf("v%0d_state", i), 32'(state_o), 32'(vecs[i].st));
      check($sformatf("v%0d_mmcm", i), 32'(mmcm_rst_o), 32'(vecs[i].mm));
      check($sformatf("v%0d_rst_out", i), 32'(rst_out), 32'(vecs[i].ro));
      check($sformatf("v%0d_ready", i), 32'(all_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d_retry", i), 32'(retry_cnt), 32'(vecs[i].ret));
      check($sformatf("v%0d_lost", i), 32'(lock_lost_cnt), 32'(vecs[i].lost));
    end

    // rst in the middle of RELEASE clears everything on the next edge
    for (int i = 0; i < 100 && rst_out !== 3'b110; i++) tick(1'b0, 1'b1);
    check("mid_rel_reached", 32'(rst_out), 32'b110);
    tick(1'b1, 1'b1);
    check("mid_rel_rst_out", 32'(rst_out), 32'b111);
    check("mid_rel_mmcm", 32'(mmcm_rst_o), 32'd1);
    check("mid_rel_state", 32'(state_o), 32'd0);
    check("mid_rel_retry", 32'(retry_cnt), 32'd0);
    check("mid_rel_lost", 32'(lock_lost_cnt), 32'd0);

    // one-cycle glitch on locked_in while STABLE count is 5
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("glitch_state", 32'(state_o), 32'd1);
    check("glitch_rst_out", 32'(rst_out), 32'b111);
    check("glitch_lost", 32'(lock_lost_cnt), 32'd0);
    wait_ready(100);

    // never lock: retries count up and saturate
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3 * (PRC + LTO); i++) tick(1'b0, 1'b0);
    check("retry3_cnt", 32'(retry_cnt), 32'd3);
    check("retry3_mmcm", 32'(mmcm_rst_o), 32'd1);
    check("retry3_rst_out", 32'(rst_out), 32'b111);
    for (int i = 0; i < 297 * (PRC + LTO); i++) tick(1'b0, 1'b0);
    check("retry_sat", 32'(retry_cnt), 32'd255);

    // repeated lock losses in RUN saturate the loss counter
    tick(1'b1, 1'b1);
    for (int n = 0; n < 300; n++) begin
      wait_ready(100);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    end
    check("lost_sat", 32'(lock_lost_cnt), 32'd255);
    check("lost_sat_state", 32'(state_o), 32'd0);

    // random lock behaviour with occasional resets against the model
    tick(1'b1, 1'b1);
    for (int n = 0; n < 4000;) begin
      logic lvl;
      int len;
      lvl = ($urandom_range(0, 3) != 0);
      len = lvl ? $urandom_range(1, 60) : $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        tick(($urandom_range(0, 499) == 0), lvl);
        n++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
